aes_key_mem_arbiter: RTL and testbench

Controller sitting in front of the 16-slot, 256-bit AES key memory in the XTS-256 block-operation datapath. It shares the memory's single read/write port between one host key-write requester and two key-read requesters (data-key engine, tweak-key engine). It tracks which slots hold a loaded key and reports reads of unloaded slots as errors instead of returning stale contents.

---
 rtl/aes_key_pkg.sv | 38 +++
 rtl/aes_rr_arb2.sv | 30 +++
 rtl/aes_key_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_aes_key_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// -----------------------------------------------------------------------------
// aes_key_pkg
// Shared constants and types for the AES key-memory arbiter and its users in
// the XTS-256 block-operation datapath.
//   ADDR_W     slot address width (16 slots)
//   KEY_W      key width in bits
//   NUM_SLOTS  number of key slots
//   ST_*       arbiter FSM state encoding
//   rdCtxT     context held for an in-flight read
//   slotMask() one-hot mask for a slot address
// -----------------------------------------------------------------------------
package aes_key_pkg;

  localparam int ADDR_W    = 4;
  localparam int KEY_W     = 256;
  localparam int NUM_SLOTS = 16;

  // FSM encoding kept as plain 2-bit constants so existing debug tooling that
  // decodes the raw state value keeps working.
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WR         = 2'd1;
  localparam logic [1:0] ST_RD_ISSUE   = 2'd2;
  localparam logic [1:0] ST_RD_CAPTURE = 2'd3;

  // Everything the capture stage needs about a granted read. The slot-valid
  // bit is frozen at grant time so later clears or writes cannot change the
  // outcome of a read that is already in flight.
  typedef struct packed {
    logic hit;    // slot held a loaded key when the read was granted
    logic idx;    // which reader owns this read (0 = data key, 1 = tweak key)
  } rdCtxT;

  function automatic logic [NUM_SLOTS-1:0] slotMask(input logic [ADDR_W-1:0] addr);
    slotMask       = '0;
    slotMask[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// -----------------------------------------------------------------------------
// aes_rr_arb2
// Two-way round-robin picker. Purely combinational; the caller owns the
// lastGrant pointer and updates it only when a grant is actually taken.
//   inReq0, inReq1  requests from reader 0 / reader 1
//   inLastGrant     index of the reader served most recently
//   outGrant        at least one request is present
//   outGrantIdx     index of the reader that wins this cycle
// -----------------------------------------------------------------------------
module aes_rr_arb2 (
  input  logic inReq0,
  input  logic inReq1,
  input  logic inLastGrant,
  output logic outGrant,
  output logic outGrantIdx
);

  always_comb begin
    outGrant    = inReq0 | inReq1;
    outGrantIdx = 1'b0;
    if (inReq0 && inReq1) begin
      // Contention: favour the reader that was not served last.
      outGrantIdx = ~inLastGrant;
    end else begin
      // A lone requester wins regardless of the pointer.
      outGrantIdx = inReq1;
    end
  end

endmodule

// File: rtl/aes_key_mem_arbiter.sv
// -----------------------------------------------------------------------------
// aes_key_mem_arbiter
// Shares the single read/write port of the 16-slot, 256-bit AES key memory
// between the host key writer and two key readers (data-key engine and
// tweak-key engine). A per-slot valid bit records which slots hold a loaded
// key; a read of an unloaded slot does not touch the memory and is returned
// as an error with all-zero data.
//
// Handshake: every requester raises its req with a stable address (and data)
// and holds both until the matching ack pulse; the ack is a one-cycle pulse
// registered at the edge that accepted the request. There is no cancel. Read
// results arrive later as a one-cycle outRdValidN pulse qualifying the shared
// outRdData / outRdErr.
//
// Ports
//   inClk, inRst             clock, synchronous active-high reset
//   inClrAll                 invalidate every slot (sampled only in IDLE)
//   inWrReq/inWrAddr/inWrData, outWrAck            host write port
//   inRdReqN/inRdAddrN, outRdAckN, outRdValidN     reader N port (N = 0,1)
//   outRdErr, outRdData                            shared read result
//   outMemWr/outMemRd/outMemAddr/outMemData        registered memory strobes
//   inMemData                memory read data, valid one cycle after outMemRd
//   outState                 current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module aes_key_mem_arbiter
  import aes_key_pkg::*;
(
  input  logic              inClk,
  input  logic              inRst,
  input  logic              inClrAll,
  input  logic              inWrReq,
  input  logic [ADDR_W-1:0] inWrAddr,
  input  logic [KEY_W-1:0]  inWrData,
  output logic              outWrAck,
  input  logic              inRdReq0,
  input  logic [ADDR_W-1:0] inRdAddr0,
  input  logic              inRdReq1,
  input  logic [ADDR_W-1:0] inRdAddr1,
  output logic              outRdAck0,
  output logic              outRdAck1,
  output logic              outRdValid0,
  output logic              outRdValid1,
  output logic              outRdErr,
  output logic [KEY_W-1:0]  outRdData,
  output logic              outMemWr,
  output logic              outMemRd,
  output logic [ADDR_W-1:0] outMemAddr,
  output logic [KEY_W-1:0]  outMemData,
  input  logic [KEY_W-1:0]  inMemData,
  output logic [1:0]        outState
);

  logic [1:0]           state;
  logic [NUM_SLOTS-1:0] slotValid;
  logic                 lastGrant;
  rdCtxT                rdCtx;

  logic                 grantAny;
  logic                 grantIdx;
  logic [ADDR_W-1:0]    grantAddr;

  aes_rr_arb2 uRrArb (
    .inReq0      (inRdReq0),
    .inReq1      (inRdReq1),
    .inLastGrant (lastGrant),
    .outGrant    (grantAny),
    .outGrantIdx (grantIdx)
  );

  assign grantAddr = grantIdx ? inRdAddr1 : inRdAddr0;
  assign outState  = state;

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state       <= ST_IDLE;
      slotValid   <= '0;
      lastGrant   <= 1'b1;        // reader 0 wins the first contention
      rdCtx       <= '0;
      outWrAck    <= 1'b0;
      outRdAck0   <= 1'b0;
      outRdAck1   <= 1'b0;
      outRdValid0 <= 1'b0;
      outRdValid1 <= 1'b0;
      outRdErr    <= 1'b0;
      outRdData   <= '0;
      outMemWr    <= 1'b0;
      outMemRd    <= 1'b0;
      outMemAddr  <= '0;
      outMemData  <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses; address, data and the read
      // result hold their last value between updates.
      outWrAck    <= 1'b0;
      outRdAck0   <= 1'b0;
      outRdAck1   <= 1'b0;
      outRdValid0 <= 1'b0;
      outRdValid1 <= 1'b0;
      outMemWr    <= 1'b0;
      outMemRd    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (inClrAll) begin
            // Clear takes the whole arbitration slot; pending requests wait.
            slotValid <= '0;
          end else if (inWrReq) begin
            state      <= ST_WR;
            outWrAck   <= 1'b1;
            outMemWr   <= 1'b1;
            outMemAddr <= inWrAddr;
            outMemData <= inWrData;
            slotValid  <= slotValid | slotMask(inWrAddr);
          end else if (grantAny) begin
            state       <= ST_RD_ISSUE;
            lastGrant   <= grantIdx;
            outRdAck0   <= ~grantIdx;
            outRdAck1   <= grantIdx;
            outMemAddr  <= grantAddr;
            // Unloaded slots never reach the memory; the error is produced
            // locally in the capture stage.
            outMemRd    <= slotValid[grantAddr];
            rdCtx.hit   <= slotValid[grantAddr];
            rdCtx.idx   <= grantIdx;
          end
        end

        // The write requester still has its request up during this cycle
        // (it only sees the ack now), so this state keeps it from being
        // accepted a second time.
        ST_WR: begin
          state <= ST_IDLE;
        end

        // Memory registers its read data at the end of this cycle.
        ST_RD_ISSUE: begin
          state <= ST_RD_CAPTURE;
        end

        // inMemData is only driven in this cycle; it is sampled nowhere else.
        ST_RD_CAPTURE: begin
          state       <= ST_IDLE;
          outRdData   <= rdCtx.hit ? inMemData : '0;
          outRdErr    <= ~rdCtx.hit;
          outRdValid0 <= ~rdCtx.idx;
          outRdValid1 <= rdCtx.idx;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_mem_arbiter.sv
module tb_aes_key_mem_arbiter;
  import aes_key_pkg::*;

  localparam int SB_W = KEY_W + 2;   // {reader, err, data}

  localparam logic [KEY_W-1:0] KEY_A5 = {32{8'hA5}};
  localparam logic [KEY_W-1:0] KEY_1  = {8{32'h1111_1111}};
  localparam logic [KEY_W-1:0] KEY_2  = {8{32'h2222_2222}};
  localparam logic [KEY_W-1:0] KEY_5  = {8{32'h5555_0F0F}};
  localparam logic [KEY_W-1:0] KEY_9  = {8{32'h9999_C3C3}};

  // ---------------------------------------------------------------- clock/reset
  logic inClk = 1'b0;
  logic inRst;
  always #5 inClk = ~inClk;

  logic              inClrAll;
  logic              inWrReq;
  logic [ADDR_W-1:0] inWrAddr;
  logic [KEY_W-1:0]  inWrData;
  logic              outWrAck;
  logic              inRdReq0, inRdReq1;
  logic [ADDR_W-1:0] inRdAddr0, inRdAddr1;
  logic              outRdAck0, outRdAck1;
  logic              outRdValid0, outRdValid1;
  logic              outRdErr;
  logic [KEY_W-1:0]  outRdData;
  logic              outMemWr, outMemRd;
  logic [ADDR_W-1:0] outMemAddr;
  logic [KEY_W-1:0]  outMemData;
  wire  [KEY_W-1:0]  inMemData;
  logic [1:0]        outState;

  aes_key_mem_arbiter dut (
    .inClk       (inClk),
    .inRst       (inRst),
    .inClrAll    (inClrAll),
    .inWrReq     (inWrReq),
    .inWrAddr    (inWrAddr),
    .inWrData    (inWrData),
    .outWrAck    (outWrAck),
    .inRdReq0    (inRdReq0),
    .inRdAddr0   (inRdAddr0),
    .inRdReq1    (inRdReq1),
    .inRdAddr1   (inRdAddr1),
    .outRdAck0   (outRdAck0),
    .outRdAck1   (outRdAck1),
    .outRdValid0 (outRdValid0),
    .outRdValid1 (outRdValid1),
    .outRdErr    (outRdErr),
    .outRdData   (outRdData),
    .outMemWr    (outMemWr),
    .outMemRd    (outMemRd),
    .outMemAddr  (outMemAddr),
    .outMemData  (outMemData),
    .inMemData   (inMemData),
    .outState    (outState)
  );

  // ---------------------------------------------------------------- key memory model
  logic [KEY_W-1:0] keyMem [NUM_SLOTS];
  logic [KEY_W-1:0] memQ;
  logic             memRdPend = 1'b0;

  always @(posedge inClk) begin
    if (outMemWr) keyMem[outMemAddr] <= outMemData;
    if (outMemRd) memQ <= keyMem[outMemAddr];
    memRdPend <= outMemRd;
  end
  assign inMemData = memRdPend ? memQ : 'z;

  // ---------------------------------------------------------------- checking
  int assertCount = 0;
  int failCount   = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic checkVal(input string tag, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every read result pulse is matched against the next expected entry.
  always @(negedge inClk) begin
    if (outRdValid0 || outRdValid1) begin
      checkVal("rdValidExcl", SB_W'(outRdValid0 & outRdValid1), SB_W'(0));
      checkVal("rdQueueNonEmpty", SB_W'(exp_q.size() != 0), SB_W'(1));
      if (exp_q.size() != 0)
        checkVal("rdResult", SB_W'({outRdValid1, outRdErr, outRdData}), exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic hostWrite(input logic [ADDR_W-1:0] a, input logic [KEY_W-1:0] d);
    int n;
    inWrReq  = 1'b1;
    inWrAddr = a;
    inWrData = d;
    n = 0;
    do begin tick(); n++; end while (!outWrAck && n < 10);
    checkVal("wrAckLatency", SB_W'(n), SB_W'(1));
    checkVal("wrMemStrobe", SB_W'({outMemWr, outMemAddr}), SB_W'({1'b1, a}));
    checkVal("wrMemData", SB_W'(outMemData), SB_W'(d));
    inWrReq = 1'b0;
    tick();
  endtask

  task automatic waitRdValid(input logic rdr);
    int n;
    n = 0;
    do begin tick(); n++; end while (!(rdr ? outRdValid1 : outRdValid0) && n < 10);
    checkVal("rdValidLatency", SB_W'(n), SB_W'(2));
  endtask

  task automatic readKey(input logic rdr, input logic [ADDR_W-1:0] a,
                         input logic [KEY_W-1:0] expData, input logic expErr);
    int n;
    logic [KEY_W-1:0] e;
    e = expErr ? '0 : expData;
    exp_q.push_back(SB_W'({rdr, expErr, e}));
    if (rdr) begin inRdReq1 = 1'b1; inRdAddr1 = a; end
    else     begin inRdReq0 = 1'b1; inRdAddr0 = a; end
    n = 0;
    do begin tick(); n++; end while (!(rdr ? outRdAck1 : outRdAck0) && n < 10);
    checkVal("rdAckLatency", SB_W'(n), SB_W'(1));
    checkVal("rdMemStrobe", SB_W'({outMemRd, outMemAddr}), SB_W'({~expErr, a}));
    if (rdr) inRdReq1 = 1'b0; else inRdReq0 = 1'b0;
    waitRdValid(rdr);
  endtask

  // ---------------------------------------------------------------- directed test
  initial begin
    int n;
    int grants;
    int lastCyc;
    logic sawPulse;

    inRst = 1'b1; inClrAll = 1'b0; inWrReq = 1'b0; inWrAddr = '0; inWrData = '0;
    inRdReq0 = 1'b0; inRdReq1 = 1'b0; inRdAddr0 = '0; inRdAddr1 = '0;
    tick(); tick();
    checkVal("resetOuts", SB_W'({outWrAck, outRdAck0, outRdAck1, outRdValid0, outRdValid1,
                                 outRdErr, outMemWr, outMemRd, outMemAddr, outState}), SB_W'(0));
    checkVal("resetRdData", SB_W'(outRdData), SB_W'(0));
    inRst = 1'b0;
    tick();

    // Basic write then read of a loaded slot.
    hostWrite(4'd3, KEY_A5);
    readKey(1'b0, 4'd3, KEY_A5, 1'b0);

    // Read of an unloaded slot.
    readKey(1'b1, 4'd7, '0, 1'b1);

    // Both readers request continuously: grants alternate 0,1,0,1, 3 cycles apart.
    hostWrite(4'd1, KEY_1);
    hostWrite(4'd2, KEY_2);
    exp_q.push_back(SB_W'({1'b0, 1'b0, KEY_1}));
    exp_q.push_back(SB_W'({1'b1, 1'b0, KEY_2}));
    exp_q.push_back(SB_W'({1'b0, 1'b0, KEY_1}));
    exp_q.push_back(SB_W'({1'b1, 1'b0, KEY_2}));
    inRdReq0 = 1'b1; inRdAddr0 = 4'd1;
    inRdReq1 = 1'b1; inRdAddr1 = 4'd2;
    grants = 0; lastCyc = 0;
    for (int cyc = 1; cyc <= 20 && grants < 4; cyc++) begin
      tick();
      if (outRdAck0 || outRdAck1) begin
        checkVal("altBothAck", SB_W'(outRdAck0 & outRdAck1), SB_W'(0));
        checkVal("altGrantIdx", SB_W'(outRdAck1), SB_W'(grants % 2));
        if (grants == 0) checkVal("altFirstCyc", SB_W'(cyc), SB_W'(1));
        else             checkVal("altSpacing", SB_W'(cyc - lastCyc), SB_W'(3));
        lastCyc = cyc;
        grants++;
      end
    end
    checkVal("altGrantCount", SB_W'(grants), SB_W'(4));
    inRdReq0 = 1'b0; inRdReq1 = 1'b0;
    tick(); tick(); tick();

    // Write and read in the same IDLE cycle: write first, read two cycles later.
    exp_q.push_back(SB_W'({1'b0, 1'b0, KEY_5}));
    inWrReq = 1'b1; inWrAddr = 4'd5; inWrData = KEY_5;
    inRdReq0 = 1'b1; inRdAddr0 = 4'd5;
    tick();
    checkVal("wrBeforeRd", SB_W'({outWrAck, outRdAck0}), SB_W'(2'b10));
    inWrReq = 1'b0;
    n = 1;
    do begin tick(); n++; end while (!outRdAck0 && n < 10);
    checkVal("rdAfterWrLat", SB_W'(n), SB_W'(3));
    checkVal("rdAfterWrMem", SB_W'({outMemRd, outMemAddr}), SB_W'({1'b1, 4'd5}));
    inRdReq0 = 1'b0;
    waitRdValid(1'b0);

    // Clear and write together: clear wins, write acked next cycle.
    inClrAll = 1'b1;
    inWrReq = 1'b1; inWrAddr = 4'd9; inWrData = KEY_9;
    tick();
    checkVal("clrWins", SB_W'({outWrAck, outMemWr}), SB_W'(0));
    inClrAll = 1'b0;
    tick();
    checkVal("wrAfterClr", SB_W'({outWrAck, outMemWr, outMemAddr}), SB_W'({2'b11, 4'd9}));
    inWrReq = 1'b0;
    tick();
    readKey(1'b0, 4'd9, KEY_9, 1'b0);
    readKey(1'b1, 4'd3, '0, 1'b1);
    readKey(1'b0, 4'd5, '0, 1'b1);

    // Clear raised while a read is in flight: the read still returns the key.
    hostWrite(4'd3, KEY_A5);
    exp_q.push_back(SB_W'({1'b1, 1'b0, KEY_A5}));
    inRdReq1 = 1'b1; inRdAddr1 = 4'd3;
    tick();
    checkVal("inflightGrant", SB_W'({outRdAck1, outMemRd}), SB_W'(2'b11));
    inRdReq1 = 1'b0;
    inClrAll = 1'b1;
    waitRdValid(1'b1);
    tick();
    checkVal("clrNoAck", SB_W'({outWrAck, outRdAck0, outRdAck1, outState}), SB_W'(0));
    inClrAll = 1'b0;
    readKey(1'b0, 4'd3, '0, 1'b1);

    // Reset during RD_ISSUE: everything returns to zero, no result pulse.
    hostWrite(4'd3, KEY_A5);
    readKey(1'b1, 4'd3, KEY_A5, 1'b0);
    inRdReq0 = 1'b1; inRdAddr0 = 4'd3;
    tick();
    checkVal("rstGrant", SB_W'({outRdAck0, outMemRd}), SB_W'(2'b11));
    inRdReq0 = 1'b0;
    inRst = 1'b1;
    tick();
    checkVal("rstOuts", SB_W'({outWrAck, outRdAck0, outRdAck1, outRdValid0, outRdValid1,
                               outRdErr, outMemWr, outMemRd, outMemAddr, outState}), SB_W'(0));
    checkVal("rstRdData", SB_W'(outRdData), SB_W'(0));
    inRst = 1'b0;
    sawPulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      sawPulse = sawPulse | outRdValid0 | outRdValid1 | outWrAck;
    end
    checkVal("rstNoPulse", SB_W'(sawPulse), SB_W'(0));
    readKey(1'b0, 4'd3, '0, 1'b1);

    tick(); tick();
    checkVal("sbDrained", SB_W'(exp_q.size()), SB_W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
